// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO. It prefetches into a 3-entry buffer that
// absorbs the FIFO's one-cycle read latency and presents the words as a valid/ready stream.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
  logic [1:0]            count, count_nxt;
  logic                  inflight, inflight_nxt;
  logic [CNT_WIDTH-1:0]  xfer_nxt;
  logic                  land;
  logic                  pop;

  // Pointers wrap 0 -> 1 -> 2 -> 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue decision uses only registered occupancy and the empty flag, never m_ready.
  always_comb begin
    fifo_rd_en   = 1'b0;
    land         = 1'b0;
    pop          = 1'b0;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    xfer_nxt     = xfer_cnt;
    m_valid      = (count != 2'd0);
    if (rstn && !flush && !fifo_empty &&
        ((3'(count) + 3'(inflight)) < 3'(DEPTH))) begin
      fifo_rd_en = 1'b1;
    end
    inflight_nxt = fifo_rd_en;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      land = inflight;
      pop  = m_valid & m_ready;
      if (land) begin
        wr_ptr_nxt = ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr_nxt = ptr_inc(rd_ptr);
        xfer_nxt   = xfer_cnt + CNT_WIDTH'(1);
      end
      if (land && !pop) begin
        count_nxt = count + 2'd1;
      end else if (pop && !land) begin
        count_nxt = count - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      inflight <= inflight_nxt;
      xfer_cnt <= xfer_nxt;
    end
  end

  // Entries are cleared on reset so m_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (land) begin
      mem[wr_ptr] <= fifo_rd_data;
    end
  end

  assign m_data = mem[rd_ptr];
  assign level  = count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO and stream model, a directed
// reset table, hand-written corner sequences, and randomized traffic.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       flush = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [1:0] level;
  logic [15:0] xfer_cnt;

  logic       rd_en4;
  logic       m_valid4;
  logic [7:0] m_data4;
  logic [1:0] level4;
  logic [3:0] xfer_cnt4;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .level(level), .xfer_cnt(xfer_cnt));

  // Narrow counter instance sees identical stimulus; only its wrap behaviour differs.
  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .fifo_rd_en(rd_en4), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .flush(flush), .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .level(level4), .xfer_cnt(xfer_cnt4));

  int n_vec = 0;
  int n_err = 0;

  // FIFO contents, and the reference: words held downstream, one word in flight, transfers.
  logic [7:0]  fq[$];
  logic [7:0]  mq[$];
  bit          m_inf;
  int unsigned m_xfer;

  int  cyc, hs, hs_first, hs_last, rd_pulses;
  bit  prev_rd;

  typedef struct {
    bit         rdy;
    bit         rd;
    bit         vld;
    logic [7:0] data;
    logic [1:0] lvl;
    logic [15:0] xfer;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  // One clock: drive inputs, compare against the model, advance FIFO and model.
  task automatic cycle(input bit fl, input bit rdy);
    bit e_rd, e_pop, s_rd;
    logic [7:0] land_d;
    flush = fl;
    m_ready = rdy;
    #1;
    e_rd  = !fl && (fq.size() != 0) && (mq.size() + int'(m_inf) < 3);
    e_pop = (mq.size() != 0) && rdy;
    check("rd_en", 32'(fifo_rd_en), 32'(e_rd));
    check("rd_en4", 32'(rd_en4), 32'(e_rd));
    check("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check("m_data", 32'(m_data), 32'(mq[0]));
    check("level", 32'(level), 32'(mq.size()));
    check("xfer_cnt", 32'(xfer_cnt), m_xfer % 65536);
    check("xfer_cnt4", 32'(xfer_cnt4), m_xfer % 16);
    check("occupancy", 32'((int'(level) + int'(prev_rd)) <= 3), 32'd1);
    s_rd = fifo_rd_en;
    land_d = fifo_rd_data;
    if (fifo_rd_en) rd_pulses++;
    if (m_valid && rdy && !fl) begin
      if (hs == 0) hs_first = cyc;
      hs_last = cyc;
      hs++;
    end
    @(posedge clk);
    #1;
    cyc++;
    prev_rd = s_rd;
    if (s_rd && fq.size() != 0) fifo_rd_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    if (fl) begin
      mq.delete();
      m_inf = 1'b0;
    end else begin
      if (e_pop) begin
        void'(mq.pop_front());
        m_xfer++;
      end
      if (m_inf) mq.push_back(land_d);
      m_inf = e_rd;
    end
  endtask

  // Asynchronous assertion mid-cycle; outputs must follow immediately.
  task automatic rst_assert(input bit clear_fifo);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_xfer", 32'(xfer_cnt), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    mq.delete();
    m_inf = 1'b0;
    m_xfer = 0;
    prev_rd = 1'b0;
    if (clear_fifo) fq.delete();
    fifo_empty = (fq.size() == 0);
    flush = 1'b0;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_release();
    rstn = 1'b1;
    hs = 0;
    rd_pulses = 0;
  endtask

  initial begin
    logic [7:0] held;
    int saved;
    int waited;
    m_inf = 1'b0; m_xfer = 0; cyc = 0; hs = 0; hs_first = 0; hs_last = 0;
    rd_pulses = 0; prev_rd = 1'b0;

    tbl[0] = '{0, 1, 0, 8'h00, 2'd0, 16'd0};
    tbl[1] = '{0, 1, 0, 8'h00, 2'd0, 16'd0};
    tbl[2] = '{0, 0, 1, 8'h11, 2'd1, 16'd0};
    tbl[3] = '{0, 0, 1, 8'h11, 2'd2, 16'd0};
    tbl[4] = '{1, 0, 1, 8'h11, 2'd2, 16'd0};
    tbl[5] = '{1, 0, 1, 8'h22, 2'd1, 16'd1};
    tbl[6] = '{0, 0, 0, 8'h00, 2'd0, 16'd2};

    // Reset and idle: FIFO holds two words while rstn is low.
    rst_assert(1'b1);
    push(8'h11);
    push(8'h22);
    @(posedge clk);
    #1;
    check("rst_rd_en_nonempty", 32'(fifo_rd_en), 32'd0);
    check("rst_valid_nonempty", 32'(m_valid), 32'd0);
    rst_release();
    for (int i = 0; i < 7; i++) begin
      m_ready = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d_rd", i), 32'(fifo_rd_en), 32'(tbl[i].rd));
      check($sformatf("tbl%0d_vld", i), 32'(m_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) check($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].data));
      check($sformatf("tbl%0d_lvl", i), 32'(level), 32'(tbl[i].lvl));
      check($sformatf("tbl%0d_xfer", i), 32'(xfer_cnt), 32'(tbl[i].xfer));
      cycle(1'b0, tbl[i].rdy);
    end

    // Streaming 64 words with m_ready held high.
    rst_assert(1'b1);
    rst_release();
    for (int i = 0; i < 64; i++) push(8'(i));
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1);
    check("stream_pops", 32'(hs), 32'd64);
    check("stream_back_to_back", 32'(hs_last - hs_first), 32'd63);
    check("stream_xfer", 32'(xfer_cnt), 32'd64);

    // Backpressure: 10 words, 8 stalled cycles, then toggling ready.
    hs = 0;
    for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
    held = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) held = m_data;
      if (i >= 4) check("stall_rd_en", 32'(fifo_rd_en), 32'd0);
      cycle(1'b0, 1'b0);
    end
    check("stall_level", 32'(level), 32'd3);
    check("stall_data", 32'(m_data), 32'(held));
    for (int i = 0; i < 30; i++) cycle(1'b0, i[0] == 1'b0);
    check("bp_all_words", 32'(hs), 32'd10);

    // Flush with two words buffered and one in flight.
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    check("pre_flush_level", 32'(level), 32'd2);
    check("pre_flush_inflight", 32'(prev_rd), 32'd1);
    saved = int'(xfer_cnt);
    cycle(1'b1, 1'b0);
    check("post_flush_valid", 32'(m_valid), 32'd0);
    check("post_flush_xfer", 32'(xfer_cnt), 32'(saved));
    waited = 0;
    while (!m_valid && waited < 10) begin
      cycle(1'b0, 1'b0);
      waited++;
    end
    check("post_flush_timeout", 32'(m_valid), 32'd1);
    check("post_flush_next_word", 32'(m_data), 32'hA3);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

    // Empty edge: a single word into an empty FIFO.
    hs = 0;
    rd_pulses = 0;
    push(8'h5A);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
    check("single_rd_pulses", 32'(rd_pulses), 32'd1);
    check("single_pops", 32'(hs), 32'd1);
    check("single_valid_after", 32'(m_valid), 32'd0);
    check("single_level_after", 32'(level), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (($urandom % 3) == 0 && fq.size() < 8) push(8'($urandom));
      cycle(($urandom % 40) == 0, ($urandom % 3) != 0);
    end

    // Reset mid-operation, then 20 transfers to wrap the narrow counter.
    for (int i = 0; i < 4; i++) push(8'($urandom));
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst_assert(1'b1);
    rst_release();
    for (int i = 0; i < 20; i++) push(8'hC0 + 8'(i));
    for (int i = 0; i < 26; i++) cycle(1'b0, 1'b1);
    check("wrap_pops", 32'(hs), 32'd20);
    check("wrap_xfer4", 32'(xfer_cnt4), 32'd4);
    check("wrap_xfer16", 32'(xfer_cnt), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
